// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer between the EX/MEM register and a
// multi-cycle data memory. Freezes the upstream pipeline while an access is
// outstanding and hands read data to MEM/WB with a one-cycle valid.
// Optional feature macro: MEM_TIMEOUT_EN (REQ watchdog of TIMEOUT_CYC cycles).
//
// Memory handshake: dmem_req is asserted in every REQ cycle and held, with
// dmem_we/dmem_addr/dmem_wdata stable, until the cycle in which dmem_ack is
// sampled high (a one-cycle pulse, dmem_rdata valid in that same cycle).
// The transfer completes on that edge; dmem_ack seen outside REQ is ignored.
// A reset may withdraw dmem_req at any time without an ack.
module mem_stage_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic              misalign_err,
  output logic              timeout_err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   acc, aligned;
  logic   stall_c, misalign_c;
  logic   tmo_hit;
  logic   timed_out;

  // A simultaneous read and write is handled as a write.
  assign acc     = mem_read | mem_write;
  assign aligned = (alu_addr[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 5) ? $clog2(TIMEOUT_CYC + 1) : 5;
  logic [CNT_W-1:0] tmo_cnt;

  // Watchdog fires in the last allowed REQ cycle if no ack is present; an ack
  // in that same cycle takes priority and completes normally.
  assign tmo_hit = (state == REQ) && !dmem_ack && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Count REQ cycles without ack; cleared while idle so every REQ starts at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (state == REQ && !dmem_ack) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Remember whether the REQ phase ended by watchdog, for the DONE cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timed_out <= 1'b0;
    end else if (state == REQ) begin
      timed_out <= tmo_hit;
    end
  end

  assign timeout_err = (state == DONE) && timed_out;
`else
  assign tmo_hit     = 1'b0;
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, stall and misalign detection.
  always_comb begin
    state_nxt  = state;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (aligned) begin
            stall_c   = 1'b1;
            state_nxt = REQ;
          end else begin
            misalign_c = 1'b1;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (dmem_ack || tmo_hit) begin
          state_nxt = DONE;
        end
      end
      // EX/MEM still holds the finished instruction here, so inputs are ignored.
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latch the request on the detect cycle; capture read data on completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rdata_out  <= '0;
    end else begin
      if (state == IDLE && acc && aligned) begin
        dmem_we    <= mem_write;
        dmem_addr  <= alu_addr;
        dmem_wdata <= wdata_in;
      end
      if (state == REQ && dmem_ack && !dmem_we) begin
        rdata_out <= dmem_rdata;
      end else if (tmo_hit) begin
        rdata_out <= '0;
      end
    end
  end

  // Request follows the state so a reset withdraws it immediately.
  assign dmem_req     = (state == REQ);
  assign stall        = reset_n & stall_c;
  assign misalign_err = reset_n & misalign_c;
  assign rdata_valid  = (state == DONE) && !dmem_we && !timed_out;
  assign state_dbg    = state;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: table-driven and hand-sequenced bench for mem_stage_ctrl
// with a read-data scoreboard fed when accesses are driven.
module tb_mem_stage_ctrl;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;

  logic              clock;
  logic              reset_n;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] wdata_in;
  logic              stall;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  logic [DATA_W-1:0] rdata_out;
  logic              rdata_valid;
  logic              misalign_err;
  logic              timeout_err;
  logic [1:0]        state_dbg;

  mem_stage_ctrl #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .alu_addr    (alu_addr),
    .wdata_in    (wdata_in),
    .stall       (stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .rdata_out   (rdata_out),
    .rdata_valid (rdata_valid),
    .misalign_err(misalign_err),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1, "bench watchdog expired");
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every valid read result must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset_n && rdata_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", 64'(rdata_valid), 64'(1'b0));
      end else begin
        chk("sb_rdata", 64'(rdata_out), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wt;         // REQ cycles before ack
    logic [31:0] rdata;
    int          exp_stall;  // total stall cycles expected
    bit          exp_mis;
    bit          exp_we;
    bit          exp_rv;
  } rec_t;

  localparam int NVEC = 9;
  rec_t vec[NVEC];

  // ---------------- driver ----------------
  task automatic run_access(input rec_t r);
    int stall_cnt;
    int req_cnt;
    int rv_cnt;
    bit stable;
    @(posedge clock); #1;
    mem_read  = r.rd;
    mem_write = r.wr;
    alu_addr  = r.addr;
    wdata_in  = r.wdata;
    dmem_ack  = 1'b0;
    if (r.exp_rv) exp_q.push_back(r.rdata);
    #1;
    chk("idle_state", 64'(state_dbg), 64'(S_IDLE));
    chk("idle_misalign", 64'(misalign_err), 64'(r.exp_mis));
    chk("idle_req", 64'(dmem_req), 64'(1'b0));
    stall_cnt = stall ? 1 : 0;
    if (r.exp_stall == 0) begin
      chk("no_stall", 64'(stall), 64'(1'b0));
      @(posedge clock); #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      #1;
      chk("misalign_pulse_end", 64'(misalign_err), 64'(1'b0));
      chk("no_req_after_drop", 64'(dmem_req), 64'(1'b0));
      return;
    end
    req_cnt = 0;
    rv_cnt  = 0;
    stable  = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      dmem_ack = 1'b0;
      if (!dmem_req) break;
      req_cnt++;
      if (dmem_addr !== r.addr || dmem_wdata !== r.wdata || dmem_we !== r.exp_we) stable = 1'b0;
      if (req_cnt == r.wt + 1) begin
        dmem_ack   = 1'b1;
        dmem_rdata = r.rdata;
      end else begin
        dmem_rdata = $urandom;
      end
      #1;
      if (stall) stall_cnt++;
      if (rdata_valid) rv_cnt++;
    end
    // DONE cycle: disturb the inputs, they must have no effect.
    alu_addr = r.addr | 32'h3;
    #1;
    chk("done_state", 64'(state_dbg), 64'(S_DONE));
    chk("done_stall", 64'(stall), 64'(1'b0));
    chk("done_req", 64'(dmem_req), 64'(1'b0));
    chk("done_misalign", 64'(misalign_err), 64'(1'b0));
    chk("done_rvalid", 64'(rdata_valid), 64'(r.exp_rv));
    chk("done_timeout_err", 64'(timeout_err), 64'(1'b0));
    if (r.exp_rv) last_rdata = r.rdata;
    chk("rdata_out", 64'(rdata_out), 64'(last_rdata));
    chk("stall_cycles", 64'(stall_cnt), 64'(r.exp_stall));
    chk("req_cycles", 64'(req_cnt), 64'(r.wt + 1));
    chk("req_stable", 64'(stable), 64'(1'b1));
    chk("no_valid_in_req", 64'(rv_cnt), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int req_cnt;
    rec_t rr;

    vec[0] = '{1'b1, 1'b0, 32'h10,  32'h0,    0, 32'hDEADBEEF, 2, 1'b0, 1'b0, 1'b1};
    vec[1] = '{1'b0, 1'b1, 32'h20,  32'h1234, 3, 32'h0,        5, 1'b0, 1'b1, 1'b0};
    vec[2] = '{1'b1, 1'b0, 32'h13,  32'h0,    0, 32'h0,        0, 1'b1, 1'b0, 1'b0};
    vec[3] = '{1'b1, 1'b0, 32'h40,  32'h0,    1, 32'hCAFEF00D, 3, 1'b0, 1'b0, 1'b1};
    vec[4] = '{1'b1, 1'b1, 32'h44,  32'h55AA, 2, 32'hA5A5A5A5, 4, 1'b0, 1'b1, 1'b0};
    vec[5] = '{1'b0, 1'b1, 32'h22,  32'h77,   0, 32'h0,        0, 1'b1, 1'b1, 1'b0};
    vec[6] = '{1'b0, 1'b0, 32'h100, 32'h0,    0, 32'h0,        0, 1'b0, 1'b0, 1'b0};
    vec[7] = '{1'b1, 1'b0, 32'h80,  32'h0,    5, 32'h0BADF00D, 7, 1'b0, 1'b0, 1'b1};
    vec[8] = '{1'b1, 1'b0, 32'h84,  32'h9,    0, 32'h13579BDF, 2, 1'b0, 1'b0, 1'b1};

    // Reset with a read pending: everything quiet.
    reset_n    = 1'b0;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    alu_addr   = 32'h10;
    wdata_in   = 32'h0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    last_rdata = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", 64'(state_dbg), 64'(S_IDLE));
    chk("rst_stall", 64'(stall), 64'(1'b0));
    chk("rst_req", 64'(dmem_req), 64'(1'b0));
    chk("rst_we", 64'(dmem_we), 64'(1'b0));
    chk("rst_addr", 64'(dmem_addr), 64'(0));
    chk("rst_wdata", 64'(dmem_wdata), 64'(0));
    chk("rst_rdata", 64'(rdata_out), 64'(0));
    chk("rst_rvalid", 64'(rdata_valid), 64'(1'b0));
    chk("rst_misalign", 64'(misalign_err), 64'(1'b0));
    chk("rst_timeout", 64'(timeout_err), 64'(1'b0));
    reset_n = 1'b1;
    #1;
    chk("post_rst_stall", 64'(stall), 64'(1'b1));
    mem_read = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_no_req", 64'(dmem_req), 64'(1'b0));

    // Table-driven accesses, issued back to back.
    for (int i = 0; i < NVEC; i++) run_access(vec[i]);

    // Random aligned accesses.
    for (int i = 0; i < 6; i++) begin
      rr.rd        = 1'($urandom_range(0, 1));
      rr.wr        = !rr.rd;
      rr.addr      = $urandom & 32'hFFFF_FFFC;
      rr.wdata     = $urandom;
      rr.wt        = $urandom_range(0, 4);
      rr.rdata     = $urandom;
      rr.exp_stall = 2 + rr.wt;
      rr.exp_mis   = 1'b0;
      rr.exp_we    = rr.wr;
      rr.exp_rv    = rr.rd;
      run_access(rr);
    end

    // Reset in the second REQ cycle, then a stray ack.
    @(posedge clock); #1;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    alu_addr  = 32'h30;
    #1;
    chk("mid_idle_stall", 64'(stall), 64'(1'b1));
    @(posedge clock); #1;
    chk("mid_req1", 64'(dmem_req), 64'(1'b1));
    @(posedge clock); #1;
    chk("mid_req2", 64'(dmem_req), 64'(1'b1));
    reset_n = 1'b0;
    #1;
    chk("mid_abort_req", 64'(dmem_req), 64'(1'b0));
    chk("mid_abort_state", 64'(state_dbg), 64'(S_IDLE));
    chk("mid_abort_stall", 64'(stall), 64'(1'b0));
    chk("mid_abort_rdata", 64'(rdata_out), 64'(0));
    last_rdata = 32'h0;
    mem_read   = 1'b0;
    @(posedge clock); #1;
    reset_n    = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF0000;
    #1;
    chk("stray_ack_req", 64'(dmem_req), 64'(1'b0));
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    #1;
    chk("stray_ack_state", 64'(state_dbg), 64'(S_IDLE));
    chk("stray_ack_rvalid", 64'(rdata_valid), 64'(1'b0));
    chk("stray_ack_rdata", 64'(rdata_out), 64'(last_rdata));

    // Recovery after the aborted access.
    run_access(vec[0]);

`ifdef MEM_TIMEOUT_EN
    // Watchdog: no ack, TIMEOUT_CYC REQ cycles, then DONE with timeout_err.
    @(posedge clock); #1;
    mem_read = 1'b1;
    alu_addr = 32'h50;
    dmem_ack = 1'b0;
    #1;
    chk("tmo_idle_stall", 64'(stall), 64'(1'b1));
    req_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      if (!dmem_req) break;
      req_cnt++;
    end
    #1;
    chk("tmo_req_cycles", 64'(req_cnt), 64'(TIMEOUT_CYC));
    chk("tmo_err", 64'(timeout_err), 64'(1'b1));
    chk("tmo_rvalid", 64'(rdata_valid), 64'(1'b0));
    chk("tmo_stall", 64'(stall), 64'(1'b0));
    chk("tmo_rdata", 64'(rdata_out), 64'(0));
    last_rdata = 32'h0;
    @(posedge clock); #1;
    mem_read = 1'b0;
    #1;
    chk("tmo_err_one_cycle", 64'(timeout_err), 64'(1'b0));
`else
    req_cnt = 0;
`endif

    @(posedge clock); #1;
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
